// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// The RX path will reuse these later.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [31:0] UART_TX_ADDR   = 32'hF6FF_F070;
  localparam logic [31:0] UART_STAT_ADDR = 32'hF6FF_F074;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_FULL_BIT = 1;
  localparam int STAT_OVF_BIT  = 2;
  localparam int STAT_CNT_LSB  = 8;

  // A depth-256 FIFO can hold 256 bytes, which does not fit the 8-bit field.
  function automatic logic [7:0] sat_count(input logic [8:0] cnt);
    return cnt[8] ? 8'hFF : cnt[7:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; o_rdata is the head entry.
// Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: address decode, sticky overflow flag and an 8N1
// serialiser fed from a byte FIFO. Loads are answered combinationally.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] TX_ADDR      = UART_TX_ADDR,
  parameter logic [31:0] STAT_ADDR    = UART_STAT_ADDR,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic        mem_we,
  input  logic [31:0] mem_write_value,
  output logic        mmio_hit,
  output logic [31:0] mmio_rdata,
  output logic        txd,
  output logic        tx_busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic          w_tx_sel;
  logic          w_stat_sel;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  logic [7:0]    w_fifo_rdata;
  logic          w_pop;
  logic          w_baud_end;
  logic [31:0]   w_status;
  logic          w_unused_wdata;

  tx_state_e     r_state;
  tx_state_e     w_state_nxt;
  logic [BW-1:0] r_baud;
  logic [BW-1:0] w_baud_nxt;
  logic [2:0]    r_bit_idx;
  logic [2:0]    w_bit_idx_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          r_ovf;

  assign w_tx_sel       = (mem_address == TX_ADDR);
  assign w_stat_sel     = (mem_address == STAT_ADDR);
  assign mmio_hit       = w_tx_sel || w_stat_sel;
  assign w_unused_wdata = ^mem_write_value[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (mem_we && w_tx_sel),
    .i_wdata (mem_write_value[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // A store that finds the FIFO full is dropped and flagged; set beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                              r_ovf <= 1'b0;
    else if (mem_we && w_tx_sel && w_fifo_full)           r_ovf <= 1'b1;
    else if (mem_we && w_stat_sel && mem_write_value[2])  r_ovf <= 1'b0;
  end

  always_comb begin
    w_status                             = '0;
    w_status[STAT_BUSY_BIT]              = tx_busy;
    w_status[STAT_FULL_BIT]              = w_fifo_full;
    w_status[STAT_OVF_BIT]               = r_ovf;
    w_status[STAT_CNT_LSB +: 8]          = sat_count(9'(w_fifo_count));
  end

  assign mmio_rdata = w_stat_sel ? w_status : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  assign w_baud_end = (r_baud == BAUD_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud + 1'b1;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_pop         = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_rdata;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_baud_end) begin
          w_baud_nxt    = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = DATA;
        end
      end
      DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit_idx == 3'd7) w_state_nxt   = STOP;
          else                   w_bit_idx_nxt = r_bit_idx + 1'b1;
        end
      end
      STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_rdata;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Decoded from flops only, so reset forces the line idle immediately.
  assign txd     = (r_state == START) ? 1'b0 :
                   (r_state == DATA)  ? r_shift[r_bit_idx] : 1'b1;
  assign tx_busy = (r_state != IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level line model checked every cycle, plus
// directed vectors with literal expectations.
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam logic [31:0] TX = 32'hF6FF_F070;
  localparam logic [31:0] ST = 32'hF6FF_F074;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_address = '0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_write_value = '0;
  logic        mmio_hit;
  logic [31:0] mmio_rdata;
  logic        txd;
  logic        tx_busy;

  mmio_uart_tx #(
    .TX_ADDR      (TX),
    .STAT_ADDR    (ST),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_address     (mem_address),
    .mem_we          (mem_we),
    .mem_write_value (mem_write_value),
    .mmio_hit        (mmio_hit),
    .mmio_rdata      (mmio_rdata),
    .txd             (txd),
    .tx_busy         (tx_busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model: each accepted byte gets an accept edge and a frame start edge.
  int         m_acc[$];
  int         m_st[$];
  logic [7:0] m_dat[$];
  logic       m_ovf = 1'b0;

  logic txd_tr  [0:8191];
  logic busy_tr [0:8191];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s cyc=%0d timed out", name, cyc);
  endtask

  // Bytes waiting in the FIFO right after edge t.
  function automatic int model_count(input int t);
    int c = 0;
    foreach (m_st[i]) if (m_acc[i] <= t && m_st[i] > t) c++;
    return c;
  endfunction

  function automatic logic model_txd(input int t);
    logic [9:0] frame;
    foreach (m_st[i]) begin
      if (t >= m_st[i] && t < m_st[i] + FRAME) begin
        frame = {1'b1, m_dat[i], 1'b0};
        return frame[(t - m_st[i]) / CPB];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic model_busy(input int t);
    foreach (m_st[i]) if (m_acc[i] <= t && t < m_st[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_status(input int t);
    int c = model_count(t);
    return {16'h0, 8'(c), 5'b0, m_ovf, (c == DEPTH), model_busy(t)};
  endfunction

  // Model update on every rising edge from the bus inputs.
  always @(posedge clk) begin
    int last_end;
    int s;
    cyc = cyc + 1;
    if (rst) begin
      m_acc.delete();
      m_st.delete();
      m_dat.delete();
      m_ovf = 1'b0;
    end else if (mem_we && mem_address == TX) begin
      if (model_count(cyc - 1) < DEPTH) begin
        last_end = (m_st.size() > 0) ? m_st[m_st.size() - 1] + FRAME : 0;
        s = (cyc + 1 > last_end) ? cyc + 1 : last_end;
        m_acc.push_back(cyc);
        m_st.push_back(s);
        m_dat.push_back(mem_write_value[7:0]);
      end else begin
        m_ovf = 1'b1;
      end
    end else if (mem_we && mem_address == ST && mem_write_value[2]) begin
      m_ovf = 1'b0;
    end
  end

  // Per-cycle compare, sampled 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cyc < 8192) begin
        txd_tr[cyc]  = txd;
        busy_tr[cyc] = tx_busy;
      end
      if (!rst) begin
        chk("txd", 32'(txd), 32'(model_txd(cyc)));
        chk("tx_busy", 32'(tx_busy), 32'(model_busy(cyc)));
        chk("mmio_hit", 32'(mmio_hit), 32'((mem_address == TX) || (mem_address == ST)));
        chk("mmio_rdata", mmio_rdata, (mem_address == ST) ? model_status(cyc) : 32'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    mem_we          = 1'b1;
    mem_address     = addr;
    mem_write_value = data;
  endtask

  task automatic idle();
    @(negedge clk);
    mem_we          = 1'b0;
    mem_address     = '0;
    mem_write_value = '0;
  endtask

  task automatic read_stat(output logic [31:0] v);
    @(negedge clk);
    mem_we      = 1'b0;
    mem_address = ST;
    #1;
    v = mmio_rdata;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] v;
    logic [9:0]  p10;
    logic [19:0] p20;
    int          n0;

    rst = 1'b1;
    wait_cycles(3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_txd", 32'(txd), 32'h1);
    chk("reset_busy", 32'(tx_busy), 32'h0);
    read_stat(v);
    chk("reset_status", v, 32'h0);

    // Reset mid-frame
    store(TX, 32'h0000_00A5);
    idle();
    @(negedge clk);
    chk("pre_rst_start_bit", 32'(txd), 32'h0);
    rst = 1'b1;
    #1;
    chk("rst_txd_async", 32'(txd), 32'h1);
    chk("rst_busy_async", 32'(tx_busy), 32'h0);
    wait_cycles(2);
    @(negedge clk);
    rst = 1'b0;
    read_stat(v);
    chk("post_rst_status", v, 32'h0);

    // Single byte 0x55
    store(TX, 32'h0000_0055);
    n0 = cyc + 1;
    idle();
    wait_cycles(FRAME + 5);
    p10 = 10'b10_1010_1010;
    for (int k = 0; k < FRAME; k++)
      chk("single_bit", 32'(txd_tr[n0 + 1 + k]), 32'(p10[k / CPB]));
    chk("single_busy_last", 32'(busy_tr[n0 + FRAME]), 32'h1);
    chk("single_busy_done", 32'(busy_tr[n0 + FRAME + 1]), 32'h0);

    // Back-to-back 0x01, 0x80
    store(TX, 32'h0000_0001);
    n0 = cyc + 1;
    store(TX, 32'h0000_0080);
    idle();
    wait_cycles(2 * FRAME + 5);
    p20 = 20'b1100000000_1000000010;
    for (int k = 0; k < 2 * FRAME; k++)
      chk("b2b_bit", 32'(txd_tr[n0 + 1 + k]), 32'(p20[k / CPB]));
    chk("b2b_busy_last", 32'(busy_tr[n0 + 2 * FRAME]), 32'h1);
    chk("b2b_busy_done", 32'(busy_tr[n0 + 2 * FRAME + 1]), 32'h0);

    // Overflow: 1 popped, 4 queued, 1 dropped
    for (int i = 0; i < 6; i++) store(TX, 32'h10 + i);
    idle();
    read_stat(v);
    chk("ovf_status", v, 32'h0000_0407);
    store(ST, 32'h0000_0004);
    idle();
    read_stat(v);
    chk("ovf_cleared", v, 32'h0000_0403);
    wait_cycles(5 * FRAME + 10);

    // Decode
    store(TX + 32'd8, 32'h0000_0077);
    #1;
    chk("decode_miss_hit", 32'(mmio_hit), 32'h0);
    @(negedge clk);
    mem_we      = 1'b0;
    mem_address = TX;
    #1;
    chk("decode_tx_hit", 32'(mmio_hit), 32'h1);
    chk("decode_tx_rdata", mmio_rdata, 32'h0);
    read_stat(v);
    chk("decode_no_enqueue", v, 32'h0);
    idle();

    // Wrap: 10 bytes with full polling, decoded back off the line
    fork
      begin
        logic [31:0] sv;
        int          guard;
        for (int b = 0; b < 10; b++) begin
          guard = 0;
          do begin
            read_stat(sv);
            guard++;
          end while (sv[1] && guard < 500);
          if (guard >= 500) timeout_fail("wrap_poll");
          mem_we          = 1'b1;
          mem_address     = TX;
          mem_write_value = 32'(b);
        end
        idle();
      end
      begin
        logic [7:0] rx;
        int         w;
        for (int j = 0; j < 10; j++) begin
          w = 0;
          do begin
            @(posedge clk);
            #1;
            w++;
          end while (txd !== 1'b0 && w < 3000);
          if (w >= 3000) timeout_fail("wrap_rx_start");
          repeat (CPB + CPB / 2) @(posedge clk);
          #1;
          rx[0] = txd;
          for (int b = 1; b < 8; b++) begin
            repeat (CPB) @(posedge clk);
            #1;
            rx[b] = txd;
          end
          repeat (CPB) @(posedge clk);
          #1;
          chk("wrap_stop_bit", 32'(txd), 32'h1);
          chk("wrap_rx_byte", 32'(rx), 32'(j));
        end
      end
    join
    wait_cycles(FRAME);
    read_stat(v);
    chk("wrap_final_status", v, 32'h0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
